// File: rtl/bubble_stream_pkg.sv
// Shared definitions for the bubble page streamer.
//
// Contents:
//   stream_state_t : playback state of the streamer (IDLE, RUN)
//   LANE_ODD       : bubble_out bit carrying the odd-loop data
//   LANE_EVEN      : bubble_out bit carrying the even-loop data
package bubble_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stream_state_t;

  localparam int LANE_ODD  = 0;
  localparam int LANE_EVEN = 1;

endpackage

// File: rtl/bubble_bank_ram.sv
// Ping-pong page store: two banks of DEPTH words, LANES bits per word.
// The bank index is the top address bit, so one flat array of 2*DEPTH
// words holds both banks. One write port, one registered read port.
// The memory has no reset so it maps onto block RAM.
//
// Ports:
//   i_clk     : clock
//   i_wr_en   : write strobe
//   i_wr_addr : {bank, word} write address
//   i_wr_data : word to write
//   i_rd_en   : read strobe; o_rd_data only changes when this is high
//   i_rd_addr : {bank, word} read address
//   o_rd_data : registered read data, valid the cycle after i_rd_en
module bubble_bank_ram #(
  parameter int LANES = 2,
  parameter int DEPTH = 2048
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH):0]   i_wr_addr,
  input  logic [LANES-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH):0]   i_rd_addr,
  output logic [LANES-1:0]         o_rd_data
);

  logic [LANES-1:0] r_mem [2*DEPTH];

  // Write port: the loader fills one bank at a time.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: the output word is held between strobes, so the read
  // register only loads when a word is actually consumed.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/bubble_page_streamer.sv
// Double-buffered page output engine for the bubble memory emulator.
// The SPI loader fills one bank while the other is streamed word by word
// onto the bubble data lanes, one word per data_out_strobe.
//
// Ports:
//   master_clock, master_reset : clock, async active-high reset
//   bubble_module_enable       : low flushes all state back to reset values
//   page_start, page_len       : start streaming the front bank from word 0;
//                                page_len of 0 or above DEPTH means DEPTH
//   data_out_strobe            : consume one word
//   fill_req, fill_bank        : a bank needs filling, and which one
//   wr_en, wr_addr, wr_data    : loader writes into fill_bank
//   fill_done                  : loader finished the requested bank
//   bubble_out                 : lane data (bit 0 odd, bit 1 even)
//   page_done                  : pulse alongside the last word of a page
//   underrun                   : pulse when page_start finds no valid bank
module bubble_page_streamer
  import bubble_stream_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DEPTH = 2048
) (
  input  logic                     master_clock,
  input  logic                     master_reset,
  input  logic                     bubble_module_enable,
  input  logic                     page_start,
  input  logic [$clog2(DEPTH):0]   page_len,
  input  logic                     data_out_strobe,
  output logic                     fill_req,
  output logic                     fill_bank,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [LANES-1:0]         wr_data,
  input  logic                     fill_done,
  output logic [LANES-1:0]         bubble_out,
  output logic                     page_done,
  output logic                     underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEN = DEPTH[AW:0];

  stream_state_t    r_state;
  logic             r_front;
  logic [1:0]       r_bank_valid;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_len_q;
  logic             r_fill_req;
  logic             r_fill_bank;
  logic             r_page_done;
  logic             r_underrun;
  logic             r_out_sel;

  logic [AW:0]      w_len_clamped;
  logic [AW:0]      w_ptr_next;
  logic             w_need_front;
  logic             w_need_back;
  logic             w_arb_req;
  logic             w_arb_bank;
  logic             w_accept_done;
  logic             w_strobe_run;
  logic             w_last;
  logic [1:0]       w_valid_next;
  logic             w_ram_wr_en;
  logic             w_ram_rd_en;
  logic [LANES-1:0] w_rd_data;

  // Page length as sampled at page_start: zero and oversized requests
  // both mean a full bank.
  always_comb begin
    w_len_clamped = page_len;
    if ((page_len == '0) || (page_len > FULL_LEN)) begin
      w_len_clamped = FULL_LEN;
    end
  end

  // Fill arbitration: the front bank has priority because it is the one
  // the next page_start needs; the back bank is prefetched otherwise.
  always_comb begin
    w_need_front = ~r_bank_valid[r_front];
    w_need_back  = ~r_bank_valid[~r_front];
    w_arb_req    = w_need_front | w_need_back;
    w_arb_bank   = w_need_front ? r_front : ~r_front;
  end

  // Stream-side events. A strobe that shares a cycle with page_start in
  // RUN is dropped, because the restart wins.
  always_comb begin
    w_accept_done = fill_done & r_fill_req;
    w_strobe_run  = (r_state == RUN) & data_out_strobe & ~page_start;
    w_ptr_next    = r_rd_ptr + (AW+1)'(1);
    w_last        = w_strobe_run & (w_ptr_next == r_len_q);
  end

  // Bank-valid merge: a completed fill and a consumed page can land in
  // the same cycle, and both must be reflected before the next
  // arbitration decision.
  always_comb begin
    w_valid_next = r_bank_valid;
    if (w_accept_done) begin
      w_valid_next[r_fill_bank] = 1'b1;
    end
    if (w_last) begin
      w_valid_next[r_front] = 1'b0;
    end
  end

  // RAM port controls. Writes are only honoured while a fill is being
  // requested so stray loader traffic cannot corrupt a valid bank.
  always_comb begin
    w_ram_wr_en = bubble_module_enable & r_fill_req & wr_en;
    w_ram_rd_en = bubble_module_enable & w_strobe_run;
  end

  bubble_bank_ram #(
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) u_bank_ram (
    .i_clk     (master_clock),
    .i_wr_en   (w_ram_wr_en),
    .i_wr_addr ({r_fill_bank, wr_addr}),
    .i_wr_data (wr_data),
    .i_rd_en   (w_ram_rd_en),
    .i_rd_addr ({r_front, r_rd_ptr[AW-1:0]}),
    .o_rd_data (w_rd_data)
  );

  // Main sequencer: playback FSM, bank bookkeeping, fill request and
  // the output-select flag. A dropped enable behaves like a reset but
  // is taken synchronously.
  always_ff @(posedge master_clock or posedge master_reset) begin
    if (master_reset) begin
      r_state      <= IDLE;
      r_front      <= 1'b0;
      r_bank_valid <= 2'b00;
      r_rd_ptr     <= '0;
      r_len_q      <= FULL_LEN;
      r_fill_req   <= 1'b0;
      r_fill_bank  <= 1'b0;
      r_page_done  <= 1'b0;
      r_underrun   <= 1'b0;
      r_out_sel    <= 1'b0;
    end else if (!bubble_module_enable) begin
      r_state      <= IDLE;
      r_front      <= 1'b0;
      r_bank_valid <= 2'b00;
      r_rd_ptr     <= '0;
      r_len_q      <= FULL_LEN;
      r_fill_req   <= 1'b0;
      r_fill_bank  <= 1'b0;
      r_page_done  <= 1'b0;
      r_underrun   <= 1'b0;
      r_out_sel    <= 1'b0;
    end else begin
      r_page_done  <= 1'b0;
      r_underrun   <= 1'b0;
      r_bank_valid <= w_valid_next;

      // fill_bank is only re-chosen while no request is outstanding, so
      // it stays frozen for the loader from request rise to fill_done.
      if (r_fill_req) begin
        if (fill_done) begin
          r_fill_req <= 1'b0;
        end
      end else if (w_arb_req) begin
        r_fill_req  <= 1'b1;
        r_fill_bank <= w_arb_bank;
      end

      // bubble_out shows RAM data after a consumed word and zero after a
      // strobe outside a page; a dropped strobe leaves it untouched.
      if (data_out_strobe && !((r_state == RUN) && page_start)) begin
        r_out_sel <= (r_state == RUN);
      end

      case (r_state)
        IDLE: begin
          if (page_start) begin
            if (r_bank_valid[r_front]) begin
              r_rd_ptr <= '0;
              r_len_q  <= w_len_clamped;
              r_state  <= RUN;
            end else begin
              r_underrun <= 1'b1;
            end
          end
        end
        RUN: begin
          if (page_start) begin
            r_rd_ptr <= '0;
            r_len_q  <= w_len_clamped;
          end else if (data_out_strobe) begin
            r_rd_ptr <= w_ptr_next;
            if (w_last) begin
              r_page_done <= 1'b1;
              r_front     <= ~r_front;
              r_state     <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign fill_req   = r_fill_req;
  assign fill_bank  = r_fill_bank;
  assign page_done  = r_page_done;
  assign underrun   = r_underrun;
  assign bubble_out = r_out_sel ? w_rd_data : '0;

endmodule

// File: tb/tb_bubble_page_streamer.sv
// Self-checking bench for bubble_page_streamer (LANES=4, DEPTH=16).
// A page-level model keeps bank contents, bank validity and the front
// bank; expected words and fill targets are derived from that model.
module tb_bubble_page_streamer;

  localparam int TB_LANES = 4;
  localparam int TB_DEPTH = 16;
  localparam int TB_AW    = $clog2(TB_DEPTH);

  logic                master_clock = 1'b0;
  logic                master_reset;
  logic                bubble_module_enable;
  logic                page_start;
  logic [TB_AW:0]      page_len;
  logic                data_out_strobe;
  logic                fill_req;
  logic                fill_bank;
  logic                wr_en;
  logic [TB_AW-1:0]    wr_addr;
  logic [TB_LANES-1:0] wr_data;
  logic                fill_done;
  logic [TB_LANES-1:0] bubble_out;
  logic                page_done;
  logic                underrun;

  int checkCount = 0;
  int passCount  = 0;

  logic [TB_LANES-1:0] modelMem [2][TB_DEPTH];
  logic                modelValid [2];
  int                  modelFront;

  bubble_page_streamer #(
    .LANES (TB_LANES),
    .DEPTH (TB_DEPTH)
  ) dut (
    .master_clock         (master_clock),
    .master_reset         (master_reset),
    .bubble_module_enable (bubble_module_enable),
    .page_start           (page_start),
    .page_len             (page_len),
    .data_out_strobe      (data_out_strobe),
    .fill_req             (fill_req),
    .fill_bank            (fill_bank),
    .wr_en                (wr_en),
    .wr_addr              (wr_addr),
    .wr_data              (wr_data),
    .fill_done            (fill_done),
    .bubble_out           (bubble_out),
    .page_done            (page_done),
    .underrun             (underrun)
  );

  always #5 master_clock = ~master_clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge master_clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  function automatic int effLen(input int len);
    if (len == 0 || len > TB_DEPTH) return TB_DEPTH;
    return len;
  endfunction

  // One cycle of stream/fill control, pulses cleared afterwards.
  task automatic applyStimulus(input logic strobe, input logic start,
                               input int len, input logic done);
    data_out_strobe = strobe;
    page_start      = start;
    page_len        = (TB_AW+1)'(len);
    fill_done       = done;
    tick();
    data_out_strobe = 1'b0;
    page_start      = 1'b0;
    fill_done       = 1'b0;
  endtask

  task automatic waitFillReq(input int expBank);
    int n;
    n = 0;
    while (fill_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("fillReqRise", 32'(fill_req), 32'(1));
    checkOutput("fillBank", 32'(fill_bank), 32'(expBank));
  endtask

  task automatic fillBank(input int bank, input logic doDone);
    logic [TB_LANES-1:0] d;
    for (int a = 0; a < TB_DEPTH; a++) begin
      d = TB_LANES'($urandom);
      wr_en   = 1'b1;
      wr_addr = TB_AW'(a);
      wr_data = d;
      modelMem[bank][a] = d;
      tick();
      wr_en = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    if (doDone) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b1);
      checkOutput("fillReqFall", 32'(fill_req), 32'(0));
      modelValid[bank] = 1'b1;
    end
  endtask

  task automatic fillNeeded();
    int b;
    while (!modelValid[0] || !modelValid[1]) begin
      b = modelValid[modelFront] ? 1 - modelFront : modelFront;
      waitFillReq(b);
      fillBank(b, 1'b1);
    end
  endtask

  // Streams one page from the model's front bank, optionally restarting
  // once after restartAt words and optionally completing a fill together
  // with the last strobe.
  task automatic streamPage(input int len, input int gap, input int restartAt,
                            input int len2, input logic mergeDone, input int mergeBank);
    int L;
    int k;
    int rs;
    rs = restartAt;
    applyStimulus(1'b0, 1'b1, len, 1'b0);
    checkOutput("noUnderrun", 32'(underrun), 32'(0));
    L = effLen(len);
    k = 0;
    while (k < L) begin
      if (rs > 0 && k == rs) begin
        applyStimulus(1'b1, 1'b1, len2, 1'b0);
        checkOutput("restartHold", 32'(bubble_out), 32'(modelMem[modelFront][k-1]));
        L  = effLen(len2);
        k  = 0;
        rs = 0;
      end else begin
        applyStimulus(1'b1, 1'b0, 0, mergeDone && (k == L - 1));
        checkOutput("streamWord", 32'(bubble_out), 32'(modelMem[modelFront][k]));
        checkOutput("pageDone", 32'(page_done), 32'(k == L - 1));
        if (mergeDone && k == L - 1)
          checkOutput("mergeReqFall", 32'(fill_req), 32'(0));
        k++;
        if (gap > 0 && k < L) begin
          for (int g = 0; g < gap; g++) tick();
          checkOutput("wordHold", 32'(bubble_out), 32'(modelMem[modelFront][k-1]));
        end
      end
    end
    tick();
    checkOutput("pageDoneLow", 32'(page_done), 32'(0));
    if (mergeDone) modelValid[mergeBank] = 1'b1;
    modelValid[modelFront] = 1'b0;
    modelFront = 1 - modelFront;
  endtask

  initial begin
    int len;
    int sel;
    int rs;
    master_reset         = 1'b1;
    bubble_module_enable = 1'b0;
    page_start           = 1'b0;
    page_len             = '0;
    data_out_strobe      = 1'b0;
    wr_en                = 1'b0;
    wr_addr              = '0;
    wr_data              = '0;
    fill_done            = 1'b0;
    modelValid[0]        = 1'b0;
    modelValid[1]        = 1'b0;
    modelFront           = 0;

    repeat (3) tick();
    checkOutput("rstFillReq", 32'(fill_req), 32'(0));
    checkOutput("rstFillBank", 32'(fill_bank), 32'(0));
    checkOutput("rstBubbleOut", 32'(bubble_out), 32'(0));
    checkOutput("rstPageDone", 32'(page_done), 32'(0));
    checkOutput("rstUnderrun", 32'(underrun), 32'(0));

    // Release reset and immediately ask for a page with no bank loaded.
    master_reset         = 1'b0;
    bubble_module_enable = 1'b1;
    applyStimulus(1'b0, 1'b1, 8, 1'b0);
    checkOutput("underrunPulse", 32'(underrun), 32'(1));
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    checkOutput("underrunLow", 32'(underrun), 32'(0));
    checkOutput("idleStrobeZero", 32'(bubble_out), 32'(0));

    // First fill goes to bank 0, then the back bank is requested.
    waitFillReq(0);
    fillBank(0, 1'b1);
    waitFillReq(1);
    streamPage(8, 2, 0, 0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    checkOutput("postPageStrobeZero", 32'(bubble_out), 32'(0));

    // Fill completing together with the last strobe of the other bank.
    fillNeeded();
    streamPage($urandom_range(1, TB_DEPTH), 0, 0, 0, 1'b0, 0);
    waitFillReq(1 - modelFront);
    fillBank(1 - modelFront, 1'b0);
    streamPage(8, 1, 0, 0, 1'b1, 1 - modelFront);
    waitFillReq(1 - modelFront);

    // Restart at word 5 of an 8-word page.
    streamPage(8, 0, 5, 8, 1'b0, 0);

    // Enable dropped mid-page, with other inputs active during the flush.
    fillNeeded();
    applyStimulus(1'b0, 1'b1, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 0, 1'b0);
      checkOutput("preFlushWord", 32'(bubble_out), 32'(modelMem[modelFront][k]));
    end
    bubble_module_enable = 1'b0;
    wr_en = 1'b1;
    applyStimulus(1'b1, 1'b1, 4, 1'b1);
    wr_en = 1'b0;
    checkOutput("flushBubbleOut", 32'(bubble_out), 32'(0));
    checkOutput("flushFillReq", 32'(fill_req), 32'(0));
    checkOutput("flushPageDone", 32'(page_done), 32'(0));
    bubble_module_enable = 1'b1;
    modelValid[0] = 1'b0;
    modelValid[1] = 1'b0;
    modelFront    = 0;
    waitFillReq(0);
    applyStimulus(1'b0, 1'b1, 4, 1'b0);
    checkOutput("flushUnderrun", 32'(underrun), 32'(1));

    // Randomised pages: lengths including 0 and oversized, gaps,
    // restarts, and loader writes that must be ignored.
    for (int p = 0; p < 40; p++) begin
      fillNeeded();
      if ($urandom_range(0, 2) == 0) begin
        for (int w = 0; w < 3; w++) begin
          wr_en   = 1'b1;
          wr_addr = TB_AW'($urandom);
          wr_data = TB_LANES'($urandom);
          tick();
        end
        wr_en = 1'b0;
      end
      sel = $urandom_range(0, 9);
      if (sel == 0) len = 0;
      else if (sel == 1) len = $urandom_range(TB_DEPTH + 1, 2 * TB_DEPTH - 1);
      else len = $urandom_range(1, TB_DEPTH);
      rs = 0;
      if (effLen(len) >= 3 && $urandom_range(0, 3) == 0)
        rs = $urandom_range(1, effLen(len) - 1);
      streamPage(len, $urandom_range(0, 3), rs, $urandom_range(0, TB_DEPTH),
                 1'b0, 0);
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        checkOutput("idleStrobeZero", 32'(bubble_out), 32'(0));
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
